branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Decode-stage branch sequencer for the 5-stage MIPS pipeline. Each cycle it inspects the branch in D and decides one of two things: stall while a needed operand is still in flight, or resolve the branch.
- On resolve it runs the branch comparison internally (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ), drives the NPC redirect and target, and tracks the delay slot.
- It keeps saturating performance counters for branches, taken branches and operand-wait stall cycles.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- d_valid  in  1  D-stage holds a valid instruction
- ext_stall  in  1  pipeline frozen by another hazard; D does not advance
- br_op  in  3  0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 illegal
- rs_val  in  32  forwarded rs value
- rt_val  in  32  forwarded rt value
- rs_ready  in  1  rs_val is final this cycle
- rt_ready  in  1  rt_val is final this cycle
- pc_d  in  32  PC of the D instruction
- imm16  in  16  branch offset field
- br_stall  out  1  stall request to F/D
- take  out  1  redirect NPC to target (valid only in the resolve cycle)
- target  out  32  branch target
- resolved  out  1  one-cycle pulse, branch decided
- in_delay_slot  out  1  current D instruction is a delay slot
- err_illegal  out  1  sticky: br_op==7 was seen with d_valid
- cnt_br  out  CNT_W  resolved branches
- cnt_taken  out  CNT_W  taken branches
- cnt_wait  out  CNT_W  cycles spent in br_stall

Behaviour:
- Reset values: state IDLE; in_delay_slot 0; err_illegal 0; all counters 0.
- Combinational outputs (br_stall, take, target, resolved) are 0 in reset cycles.
- Reset asserted in WAIT returns the FSM to IDLE with no resolve.

Operand readiness and branch detection:
- is_br = d_valid && br_op in 1..6.
- need_rt = (br_op==1 || br_op==2).
- ops_ok = rs_ready && (rt_ready || !need_rt).

Comparison (signed):
- BEQ: rs==rt
- BNE: rs!=rt
- BLEZ: rs<=0
- BGTZ: rs>0
- BLTZ: rs<0
- BGEZ: rs>=0

Target:
- target = pc_d + 4 + (sign_ext(imm16) << 2), modulo 2^32, wrap-around allowed.
- target is driven whenever is_br is true; it is 0 otherwise.

FSM states:
- IDLE: no branch pending.
- WAIT: branch held in D waiting on operands.

IDLE transitions:
- is_br && !ops_ok → WAIT, br_stall=1 this cycle.
- is_br && ops_ok && !ext_stall → resolve this cycle (zero-latency), stay IDLE.

WAIT transitions:
- br_stall=1 while !ops_ok.
- When ops_ok && !ext_stall → resolve, go to IDLE.
- If d_valid drops (flush) → IDLE, no resolve.

Resolve cycle:
- resolved=1; take = comparison result; br_stall=0.
- Operand values are read in that cycle.

ext_stall:
- While ext_stall=1, no resolve occurs and the state holds (IDLE stays IDLE).
- br_stall is still driven by the operand condition.

Delay slot:
- in_delay_slot is set on the clock edge after a resolve.
- It is cleared on the first subsequent edge with ext_stall=0 && br_stall=0, i.e. when the slot instruction leaves D.
- A branch occupying the delay slot is resolved normally; that case is not an error.

Counters (all saturate at 2^CNT_W-1, no wrap):
- cnt_br += resolved.
- cnt_taken += resolved && take.
- cnt_wait += br_stall.

err_illegal:
- Set when d_valid && br_op==7, cleared only by reset.
- br_op 7 is otherwise treated as no branch.

Non-branch instruction (br_op==0): all strobes 0 and the FSM is unaffected.

Test Plan:
- BEQ: rs=rt=0x5, ready, pc_d=0x3000, imm16=0x0004 → same cycle resolved=1, take=1, target=0x3014; next cycle in_delay_slot=1; cnt_br=1, cnt_taken=1.
- BLTZ: rs=0x80000000 → take=1. BGTZ with rs=0 → take=0. BLEZ with rs=0 → take=1. BGEZ with rs=0xFFFFFFFF → take=0.
- BNE with rt_ready=0 for 3 cycles, then 1 → br_stall=1 for 3 cycles; resolve on the 4th cycle; cnt_wait=3. A BGEZ with rt_ready=0 and rs_ready=1 resolves with no stall.
- ops_ok with ext_stall=1 for 2 cycles → no resolved pulse; the pulse arrives in the first cycle ext_stall=0. Reset asserted while in WAIT → IDLE, counters 0, no resolve.
- Target wrap: pc_d=0xFFFFFFF8, imm16=0x0001 → target=0x00000000. pc_d=0x3000, imm16=0xFFFF → target=0x3000.
- CNT_W=4: 20 taken branches → cnt_br=cnt_taken=15 (saturated). br_op=7 with d_valid → err_illegal=1 sticky, no stall, no resolve.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Decode-stage branch sequencer for a 5-stage MIPS pipeline. Each cycle it
// looks at the branch in D. It either stalls F/D while a needed operand is
// still in flight, or it resolves the branch. On resolve it evaluates the
// branch condition, drives the NPC redirect and target, and arms the
// delay-slot flag. Saturating counters track branches, taken branches and
// operand-wait stall cycles.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   d_valid        D stage holds a valid instruction
//   ext_stall      pipeline frozen by another hazard (D does not advance)
//   br_op[2:0]     0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ,
//                  7 illegal
//   rs_val/rt_val  forwarded operand values
//   rs_ready       rs_val is final this cycle
//   rt_ready       rt_val is final this cycle
//   pc_d           PC of the D instruction
//   imm16          branch offset field
//   br_stall       stall request to F/D
//   take           redirect NPC to target (meaningful in the resolve cycle)
//   target         branch target (0 when D holds no branch)
//   resolved       one-cycle pulse: branch decided
//   in_delay_slot  the current D instruction is a delay slot
//   err_illegal    sticky: br_op==7 seen with d_valid
//   cnt_br         resolved branches (saturating)
//   cnt_taken      taken branches (saturating)
//   cnt_wait       cycles spent in br_stall (saturating)
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic             ext_stall,
    input  logic [2:0]       br_op,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic [31:0]      pc_d,
    input  logic [15:0]      imm16,
    output logic             br_stall,
    output logic             take,
    output logic [31:0]      target,
    output logic             resolved,
    output logic             in_delay_slot,
    output logic             err_illegal,
    output logic [CNT_W-1:0] cnt_br,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_wait
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_BLEZ = 3'd3;
    localparam logic [2:0] OP_BGTZ = 3'd4;
    localparam logic [2:0] OP_BLTZ = 3'd5;
    localparam logic [2:0] OP_BGEZ = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_in_delay_slot;
    logic              r_err_illegal;
    logic [CNT_W-1:0]  r_cnt_br;
    logic [CNT_W-1:0]  r_cnt_taken;
    logic [CNT_W-1:0]  r_cnt_wait;

    logic              w_is_br;
    logic              w_need_rt;
    logic              w_ops_ok;
    logic              w_cmp;
    logic signed [31:0] w_rs_s;
    logic [31:0]       w_offset;
    logic [31:0]       w_target_calc;

    // ------------------------------------------------------------------
    // Branch detection, operand readiness, condition and target
    // ------------------------------------------------------------------
    assign w_is_br   = d_valid && (br_op != 3'd0) && (br_op != OP_ILL);
    // Only the two-register compares wait on rt; the zero-compares ignore it.
    assign w_need_rt = (br_op == OP_BEQ) || (br_op == OP_BNE);
    assign w_ops_ok  = rs_ready && (rt_ready || !w_need_rt);

    assign w_rs_s        = $signed(rs_val);
    assign w_offset      = {{14{imm16[15]}}, imm16, 2'b00};
    assign w_target_calc = pc_d + 32'd4 + w_offset;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        w_cmp = 1'b0;
        case (br_op)
            OP_BEQ:  w_cmp = (rs_val == rt_val);
            OP_BNE:  w_cmp = (rs_val != rt_val);
            OP_BLEZ: w_cmp = (w_rs_s <= 32'sd0);
            OP_BGTZ: w_cmp = (w_rs_s >  32'sd0);
            OP_BLTZ: w_cmp = (w_rs_s <  32'sd0);
            OP_BGEZ: w_cmp = (w_rs_s >= 32'sd0);
            default: w_cmp = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next state and combinational strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        br_stall     = 1'b0;
        resolved     = 1'b0;
        take         = 1'b0;
        target       = 32'd0;

        if (!reset) begin
            if (w_is_br) begin
                target = w_target_calc;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_is_br) begin
                        if (!w_ops_ok) begin
                            br_stall = 1'b1;
                            // A frozen pipeline holds the FSM where it is.
                            if (!ext_stall) begin
                                w_state_next = ST_WAIT;
                            end
                        end else if (!ext_stall) begin
                            // Zero-latency resolve: operands already final.
                            resolved = 1'b1;
                            take     = w_cmp;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!w_is_br) begin
                        // The waiting branch was flushed out of D.
                        w_state_next = ST_IDLE;
                    end else if (!w_ops_ok) begin
                        br_stall = 1'b1;
                    end else if (!ext_stall) begin
                        resolved     = 1'b1;
                        take         = w_cmp;
                        w_state_next = ST_IDLE;
                    end
                end

                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, delay slot, sticky error and saturating counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            r_state         <= ST_IDLE;
            r_in_delay_slot <= 1'b0;
            r_err_illegal   <= 1'b0;
            r_cnt_br        <= '0;
            r_cnt_taken     <= '0;
            r_cnt_wait      <= '0;
        end else begin
            r_state <= w_state_next;

            // The slot instruction enters D on the edge after a resolve and
            // leaves on the first edge where D is free to advance.
            if (resolved) begin
                r_in_delay_slot <= 1'b1;
            end else if (!ext_stall && !br_stall) begin
                r_in_delay_slot <= 1'b0;
            end

            if (d_valid && (br_op == OP_ILL)) begin
                r_err_illegal <= 1'b1;
            end

            if (resolved && (r_cnt_br != CNT_MAX)) begin
                r_cnt_br <= r_cnt_br + CNT_ONE;
            end
            if (resolved && take && (r_cnt_taken != CNT_MAX)) begin
                r_cnt_taken <= r_cnt_taken + CNT_ONE;
            end
            if (br_stall && (r_cnt_wait != CNT_MAX)) begin
                r_cnt_wait <= r_cnt_wait + CNT_ONE;
            end
        end
    end

    assign in_delay_slot = r_in_delay_slot;
    assign err_illegal   = r_err_illegal;
    assign cnt_br        = r_cnt_br;
    assign cnt_taken     = r_cnt_taken;
    assign cnt_wait      = r_cnt_wait;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Scoreboard bench. A driver applies one stimulus vector per cycle shortly
// after the rising edge, asks a behavioural reference model for the expected
// outputs of that cycle and pushes them into a queue. A monitor on the falling
// edge pops the queue and compares against two DUT instances (CNT_W=32 and
// CNT_W=4) that share the same inputs.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    typedef struct {
        logic        reset;
        logic        d_valid;
        logic        ext_stall;
        logic [2:0]  br_op;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic        rs_ready;
        logic        rt_ready;
        logic [31:0] pc_d;
        logic [15:0] imm16;
    } stim_t;

    typedef struct {
        logic        br_stall;
        logic        take;
        logic [31:0] target;
        logic        resolved;
        logic        in_delay_slot;
        logic        err_illegal;
        logic [31:0] cnt_br;
        logic [31:0] cnt_taken;
        logic [31:0] cnt_wait;
        logic [3:0]  c4_br;
        logic [3:0]  c4_taken;
        logic [3:0]  c4_wait;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic        ext_stall;
    logic [2:0]  br_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_ready;
    logic        rt_ready;
    logic [31:0] pc_d;
    logic [15:0] imm16;

    logic        br_stall, take, resolved, in_delay_slot, err_illegal;
    logic [31:0] target;
    logic [31:0] cnt_br, cnt_taken, cnt_wait;

    logic        s4_br_stall, s4_take, s4_resolved, s4_in_delay_slot, s4_err_illegal;
    logic [31:0] s4_target;
    logic [3:0]  s4_cnt_br, s4_cnt_taken, s4_cnt_wait;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];

    // Reference model state: what the registered outputs will show after the
    // next rising edge.
    logic    m_ds  = 1'b0;
    logic    m_err = 1'b0;
    longint  m_br  = 0, m_taken = 0, m_wait = 0;
    longint  m4_br = 0, m4_taken = 0, m4_wait = 0;

    branch_resolve_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .ext_stall(ext_stall),
        .br_op(br_op), .rs_val(rs_val), .rt_val(rt_val),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .pc_d(pc_d), .imm16(imm16),
        .br_stall(br_stall), .take(take), .target(target), .resolved(resolved),
        .in_delay_slot(in_delay_slot), .err_illegal(err_illegal),
        .cnt_br(cnt_br), .cnt_taken(cnt_taken), .cnt_wait(cnt_wait)
    );

    branch_resolve_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .d_valid(d_valid), .ext_stall(ext_stall),
        .br_op(br_op), .rs_val(rs_val), .rt_val(rt_val),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .pc_d(pc_d), .imm16(imm16),
        .br_stall(s4_br_stall), .take(s4_take), .target(s4_target),
        .resolved(s4_resolved), .in_delay_slot(s4_in_delay_slot),
        .err_illegal(s4_err_illegal),
        .cnt_br(s4_cnt_br), .cnt_taken(s4_cnt_taken), .cnt_wait(s4_cnt_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic longint sat_inc(input longint v, input bit inc, input longint cap);
        if (inc && v < cap) return v + 1;
        return v;
    endfunction

    // Behavioural reference: outputs of one cycle are a pure function of the
    // inputs (stall if an operand is missing, otherwise resolve unless the
    // pipeline is frozen); the registered outputs come from the model state.
    function automatic exp_t model_cycle(input stim_t s);
        exp_t   e;
        bit     is_br, need_rt, ops_ok, cond, stall, res;
        int     rs_i, rt_i;
        longint off;
        rs_i    = int'(s.rs_val);
        rt_i    = int'(s.rt_val);
        is_br   = s.d_valid && s.br_op >= 1 && s.br_op <= 6;
        need_rt = (s.br_op == 1) || (s.br_op == 2);
        ops_ok  = s.rs_ready && (s.rt_ready || !need_rt);
        case (s.br_op)
            3'd1:    cond = (rs_i == rt_i);
            3'd2:    cond = (rs_i != rt_i);
            3'd3:    cond = (rs_i <= 0);
            3'd4:    cond = (rs_i >  0);
            3'd5:    cond = (rs_i <  0);
            3'd6:    cond = (rs_i >= 0);
            default: cond = 0;
        endcase
        stall = !s.reset && is_br && !ops_ok;
        res   = !s.reset && is_br && ops_ok && !s.ext_stall;
        off   = longint'($signed(s.imm16)) * 4;

        e.br_stall      = stall;
        e.resolved      = res;
        e.take          = res && cond;
        e.target        = (!s.reset && is_br) ? 32'(longint'(s.pc_d) + 4 + off) : 32'd0;
        e.in_delay_slot = m_ds;
        e.err_illegal   = m_err;
        e.cnt_br        = 32'(m_br);
        e.cnt_taken     = 32'(m_taken);
        e.cnt_wait      = 32'(m_wait);
        e.c4_br         = 4'(m4_br);
        e.c4_taken      = 4'(m4_taken);
        e.c4_wait       = 4'(m4_wait);

        if (s.reset) begin
            m_ds = 0; m_err = 0;
            m_br = 0; m_taken = 0; m_wait = 0;
            m4_br = 0; m4_taken = 0; m4_wait = 0;
        end else begin
            if (res) m_ds = 1;
            else if (!s.ext_stall && !stall) m_ds = 0;
            if (s.d_valid && s.br_op == 3'd7) m_err = 1;
            m_br     = sat_inc(m_br,     res,         64'hFFFF_FFFF);
            m_taken  = sat_inc(m_taken,  res && cond, 64'hFFFF_FFFF);
            m_wait   = sat_inc(m_wait,   stall,       64'hFFFF_FFFF);
            m4_br    = sat_inc(m4_br,    res,         15);
            m4_taken = sat_inc(m4_taken, res && cond, 15);
            m4_wait  = sat_inc(m4_wait,  stall,       15);
        end
        return e;
    endfunction

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        reset     = s.reset;
        d_valid   = s.d_valid;
        ext_stall = s.ext_stall;
        br_op     = s.br_op;
        rs_val    = s.rs_val;
        rt_val    = s.rt_val;
        rs_ready  = s.rs_ready;
        rt_ready  = s.rt_ready;
        pc_d      = s.pc_d;
        imm16     = s.imm16;
        exp_q.push_back(model_cycle(s));
    endtask

    task automatic br(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic rsr, input logic rtr, input logic [31:0] pc,
                      input logic [15:0] imm, input logic ext);
        stim_t s;
        s = '{reset: 1'b0, d_valid: 1'b1, ext_stall: ext, br_op: op, rs_val: rs,
              rt_val: rt, rs_ready: rsr, rt_ready: rtr, pc_d: pc, imm16: imm};
        drive(s);
    endtask

    task automatic idle(input logic rst);
        stim_t s;
        s = '{reset: rst, d_valid: 1'b0, ext_stall: 1'b0, br_op: 3'd0, rs_val: 32'd0,
              rt_val: 32'd0, rs_ready: 1'b1, rt_ready: 1'b1, pc_d: 32'h100, imm16: 16'd0};
        drive(s);
    endtask

    // Monitor: compares whatever the DUT presents against the queued response.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("br_stall",      {31'd0, br_stall},      {31'd0, e.br_stall});
            check("resolved",      {31'd0, resolved},      {31'd0, e.resolved});
            check("take",          {31'd0, take},          {31'd0, e.take});
            check("target",        target,                 e.target);
            check("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, e.in_delay_slot});
            check("err_illegal",   {31'd0, err_illegal},   {31'd0, e.err_illegal});
            check("cnt_br",        cnt_br,                 e.cnt_br);
            check("cnt_taken",     cnt_taken,              e.cnt_taken);
            check("cnt_wait",      cnt_wait,               e.cnt_wait);
            check("w4_resolved",   {31'd0, s4_resolved},   {31'd0, e.resolved});
            check("w4_cnt_br",     {28'd0, s4_cnt_br},     {28'd0, e.c4_br});
            check("w4_cnt_taken",  {28'd0, s4_cnt_taken},  {28'd0, e.c4_taken});
            check("w4_cnt_wait",   {28'd0, s4_cnt_wait},   {28'd0, e.c4_wait});
        end
    end

    initial begin
        stim_t s;
        int    guard;
        reset = 1'b1; d_valid = 1'b0; ext_stall = 1'b0; br_op = 3'd0;
        rs_val = '0; rt_val = '0; rs_ready = 1'b1; rt_ready = 1'b1;
        pc_d = '0; imm16 = '0;

        idle(1'b1);
        idle(1'b1);

        // BEQ equal operands, resolves in the same cycle, slot flag next.
        br(3'd1, 32'h5, 32'h5, 1, 1, 32'h3000, 16'h0004, 0);
        idle(1'b0);
        idle(1'b0);

        // Sign-sensitive zero compares.
        br(3'd5, 32'h8000_0000, 32'd0, 1, 1, 32'h400, 16'h0010, 0); idle(1'b0);
        br(3'd4, 32'h0,         32'd0, 1, 1, 32'h400, 16'h0010, 0); idle(1'b0);
        br(3'd3, 32'h0,         32'd0, 1, 1, 32'h400, 16'h0010, 0); idle(1'b0);
        br(3'd6, 32'hFFFF_FFFF, 32'd0, 1, 1, 32'h400, 16'h0010, 0); idle(1'b0);

        // BNE waiting three cycles on rt, then resolving.
        repeat (3) br(3'd2, 32'h1, 32'h2, 1, 0, 32'h500, 16'h0008, 0);
        br(3'd2, 32'h1, 32'h2, 1, 1, 32'h500, 16'h0008, 0);
        idle(1'b0);

        // BGEZ does not need rt.
        br(3'd6, 32'h7, 32'h0, 1, 0, 32'h600, 16'h0002, 0); idle(1'b0);

        // Operands ready but pipeline frozen for two cycles.
        repeat (2) br(3'd1, 32'h9, 32'h9, 1, 1, 32'h700, 16'h0001, 1);
        br(3'd1, 32'h9, 32'h9, 1, 1, 32'h700, 16'h0001, 0);
        idle(1'b0);

        // Reset while a branch is waiting.
        repeat (2) br(3'd2, 32'h1, 32'h2, 1, 0, 32'h800, 16'h0001, 0);
        s = '{reset: 1'b1, d_valid: 1'b1, ext_stall: 1'b0, br_op: 3'd2, rs_val: 32'h1,
              rt_val: 32'h2, rs_ready: 1'b1, rt_ready: 1'b1, pc_d: 32'h800, imm16: 16'h1};
        drive(s);
        idle(1'b0);

        // Target arithmetic wrap-around and negative offset.
        br(3'd6, 32'h0, 32'h0, 1, 1, 32'hFFFF_FFF8, 16'h0001, 0); idle(1'b0);
        br(3'd6, 32'h0, 32'h0, 1, 1, 32'h0000_3000, 16'hFFFF, 0); idle(1'b0);

        // Twenty taken branches: the 4-bit instance saturates.
        repeat (20) br(3'd1, 32'h3, 32'h3, 1, 1, 32'h900, 16'h0004, 0);
        idle(1'b0);

        // Illegal op: sticky error, no stall, no resolve.
        br(3'd7, 32'h0, 32'h0, 0, 0, 32'hA00, 16'h0004, 0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            s.reset     = (r == 0);
            s.d_valid   = ($urandom_range(0, 9) != 0);
            s.ext_stall = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 99);
            s.br_op     = (r < 2) ? 3'd7 : (r < 20) ? 3'd0 : 3'($urandom_range(1, 6));
            case ($urandom_range(0, 3))
                0:       s.rs_val = 32'd0;
                1:       s.rs_val = 32'hFFFF_FFFF;
                2:       s.rs_val = 32'h8000_0000;
                default: s.rs_val = $urandom_range(0, 3);
            endcase
            s.rt_val    = ($urandom_range(0, 1) != 0) ? s.rs_val : 32'($urandom_range(0, 3));
            s.rs_ready  = ($urandom_range(0, 3) != 0);
            s.rt_ready  = ($urandom_range(0, 3) != 0);
            s.pc_d      = $urandom;
            s.imm16     = 16'($urandom);
            drive(s);
        end
        idle(1'b0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
